// File: rtl/prod_acc.sv
// prod_acc: accumulates groups of N unsigned 16-bit products from the array
// multiplier and presents each group sum on a held valid/ready output.
// Accumulation of the next group overlaps with a stalled consumer; only the
// product that would complete the next group waits for the held result.
// Optional feature: define PROD_ACC_SAT_EN for saturating accumulation with a
// per-group overflow flag. Without it the sum wraps and ovf is tied low.
module prod_acc #(
  parameter int ACC_W = 24,
  parameter int N     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prod_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [ACC_W-1:0] acc_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [ACC_W-1:0] res_p1;
  logic             vld_p1;
  logic [ACC_W-1:0] sum_nxt;
  logic             last;
  logic             accept;

`ifdef PROD_ACC_SAT_EN
  logic aovf_p0;
  logic rovf_p1;
  logic carry_nxt;

  // Returns {carry, sum}; on carry the sum clamps to all ones.
  function automatic logic [SUM_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [15:0]      p);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + SUM_W'(p);
    if (s[ACC_W]) sat_add = {1'b1, {ACC_W{1'b1}}};
    else          sat_add = s;
  endfunction
`else
  // Plain modulo-2^ACC_W accumulation.
  function automatic logic [ACC_W-1:0] wrap_add(input logic [ACC_W-1:0] a,
                                                input logic [15:0]      p);
    wrap_add = a + ACC_W'(p);
  endfunction
`endif

  assign last     = (cnt_p0 == LAST);
  assign in_ready = !rst && !clear && !(last && vld_p1 && !out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (cnt_p0 != '0);
  assign acc_out  = res_p1;
  assign out_valid = vld_p1;

  // Next running sum for the product being offered this cycle.
  always_comb begin
`ifdef PROD_ACC_SAT_EN
    {carry_nxt, sum_nxt} = sat_add(acc_p0, prod_in);
`else
    sum_nxt = wrap_add(acc_p0, prod_in);
`endif
  end

  // Stage 0 -> 1 boundary: accumulate, close groups into the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      res_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (vld_p1 && out_ready) vld_p1 <= 1'b0;
      if (clear) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else if (accept) begin
        if (last) begin
          res_p1 <= sum_nxt;
          vld_p1 <= 1'b1;
          acc_p0 <= '0;
          cnt_p0 <= '0;
        end else begin
          acc_p0 <= sum_nxt;
          cnt_p0 <= cnt_p0 + 1'b1;
        end
      end
    end
  end

`ifdef PROD_ACC_SAT_EN
  // Sticky per-group saturation flag and the flag published with each result.
  always_ff @(posedge clk) begin
    if (rst) begin
      aovf_p0 <= 1'b0;
      rovf_p1 <= 1'b0;
    end else if (clear) begin
      aovf_p0 <= 1'b0;
    end else if (accept) begin
      if (last) begin
        rovf_p1 <= aovf_p0 | carry_nxt;
        aovf_p0 <= 1'b0;
      end else begin
        aovf_p0 <= aovf_p0 | carry_nxt;
      end
    end
  end

  assign ovf = rovf_p1;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/prod_acc.md
Name: prod_acc

Overview:
- Downstream accumulation stage for the 8x8 array multiplier `ary_mul`.
- Consumes its 16-bit unsigned products through a valid/ready handshake and sums groups of N products (dot-product lanes).
- Presents each group sum on a held output register with its own valid/ready handshake.
- Accumulation of the next group overlaps with the wait for the downstream consumer.

Parameters:
- ACC_W, 24, accumulator and result width in bits. Must be >= 16. Must be >= 16+clog2(N) for exact results unless PROD_ACC_SAT_EN is defined.
- N, 8, products per group, >= 2. Group counter width is clog2(N).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- prod_in  in  16  unsigned product from multiplier.
- in_valid  in  1  prod_in valid.
- in_ready  out  1  stage can accept prod_in this cycle.
- clear  in  1  synchronous abort of the partial group.
- acc_out  out  ACC_W  group sum.
- out_valid  out  1  acc_out valid.
- out_ready  in  1  consumer accepts acc_out.
- ovf  out  1  saturation occurred in the group now on acc_out.
- busy  out  1  partial group in progress (cnt != 0).

Behaviour:
- Internal state:
  - acc[ACC_W-1:0] running sum.
  - cnt group index, 0..N-1.
  - res register (drives acc_out), res_valid (drives out_valid), res_ovf (drives ovf).
  - acc_ovf, the sticky saturation flag for the current group.
- Reset (rst=1 at edge): acc=0, cnt=0, acc_out=0, out_valid=0, ovf=0, acc_ovf=0. Reset has priority over every other input. A partial group or held result present at reset is discarded.
- in_ready is combinational:
  - in_ready = !rst && !clear && !(cnt==N-1 && out_valid && !out_ready).
  - in_ready never depends on in_valid.
- Accept = in_valid && in_ready.
- Accept with cnt < N-1: acc <= acc + zero_ext(prod_in); cnt <= cnt+1.
- Accept with cnt == N-1 (group complete):
  - acc_out <= acc + zero_ext(prod_in); out_valid <= 1; ovf <= group saturation status.
  - acc <= 0; cnt <= 0; acc_ovf <= 0.
- Latency: result valid on acc_out exactly 1 cycle after the accept of the Nth product.
- Output handshake:
  - out_valid stays 1 and acc_out/ovf stay stable until out_valid && out_ready.
  - Transfer with no new completion in the same cycle: out_valid <= 0 next cycle.
  - Transfer and completion in the same cycle: the new result loads and out_valid stays 1. No bubble.
- Back-pressure: products 1..N-1 of the next group are accepted while a result is held. Product N stalls (in_ready=0) until out_ready=1.
- clear (with rst=0): acc <= 0, cnt <= 0, acc_ovf <= 0.
  - in_ready=0 during clear, so no product is lost mid-handshake.
  - The held result and the output handshake are unaffected by clear.
- Arithmetic: unsigned. Without saturation the sum wraps modulo 2^ACC_W.
- busy = (cnt != 0), registered-state decode.
- acc_out and ovf are undefined only in the sense that they may hold stale values when out_valid=0. The bench checks them only when out_valid=1.

Optional Feature:
- Macro PROD_ACC_SAT_EN.
- Defined:
  - Each addition detects carry out of bit ACC_W-1.
  - On carry, the sum clamps to all ones and acc_ovf is set. acc_ovf is sticky for the rest of the group.
  - Once acc_ovf is set, acc stays at all ones.
  - On completion, ovf <= acc_ovf OR carry of the final add.
- Not defined:
  - Wrapping addition; ovf tied 0.
  - No saturation logic synthesised.

Test Plan:
- ACC_W=24, N=8, out_ready=1: reset, then 8 back-to-back products of 65025 -> acc_out=520200 (0x07F008), out_valid=1 one cycle after the 8th accept, in_ready=1 throughout, ovf=0.
- Back-pressure: products 1..8 -> acc_out=36, out_ready=0; feed 8 more of 10 -> 7 accepted, in_ready=0 on the 8th. Pulse out_ready -> 36 transfers and 80 loads the same cycle with out_valid held 1. Second transfer -> out_valid=0.
- clear: 3 products of 100, clear=1 for one cycle (in_valid=1 during it, not accepted), then 8 products of 2 -> acc_out=16, busy=0 after completion.
- Reset mid-operation: result 36 held (out_valid=1) plus 5 partial products; assert rst one cycle -> out_valid=0, busy=0, acc_out=0. Next 8 products of 1 -> 8.
- ACC_W=17, N=4, 4 products of 65025:
  - PROD_ACC_SAT_EN defined -> acc_out=131071, ovf=1.
  - Not defined -> acc_out=129028, ovf=0.
  - Next group of 4x1 -> acc_out=4, ovf=0.
